// File: rtl/float_to_pcm.sv
// Output stage: IEEE-754 single-precision samples to saturated signed PCM.
// Three-stage pipeline (classify, align, sign/saturate) with a clip-event counter.
module float_to_pcm #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OUT_W = 24,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_clip,
   input  logic             clip_clr,
   output logic [CNT_W-1:0] clip_cnt
);

   localparam int unsigned MAN_W = 23;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned K_W   = 10;
   localparam int unsigned WIDE_W = 64;

   // k = e - 127 + OUT_W - 1, kept modulo 2^K_W so the add stays unsigned
   localparam logic [K_W-1:0]        K_OFS   = K_W'(OUT_W + 1024 - 128);
   localparam logic signed [K_W-1:0] K_MAX   = K_W'(OUT_W - 1);
   localparam logic signed [K_W-1:0] K_SIG   = K_W'(MAN_W);
   localparam logic [OUT_W-1:0]      PCM_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]      PCM_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]      CNT_MAX = '1;

   typedef enum logic [1:0] {
      CL_NUM  = 2'd0,
      CL_ZERO = 2'd1,
      CL_INF  = 2'd2
   } cls_t;

   logic                  en;

   logic                  s1_v;
   logic                  s1_sign;
   cls_t                  s1_cls;
   logic signed [K_W-1:0] s1_k;
   logic [MAN_W-1:0]      s1_man;

   logic                  s2_v;
   logic                  s2_sign;
   logic                  s2_ovf;
   logic [OUT_W-1:0]      s2_mag;

   logic [EXP_W-1:0]      in_exp;
   logic [MAN_W-1:0]      in_man;
   cls_t                  s1_cls_n;
   logic signed [K_W-1:0] s1_k_n;

   logic [WIDE_W-1:0]     sig_wide;
   logic                  s2_ovf_n;
   logic [OUT_W-1:0]      s2_mag_n;

   logic [OUT_W-1:0]      s3_data_n;
   logic                  s3_clip_n;

   // Whole pipe moves in lockstep; stalls only when the output is held.
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   assign in_exp = in_data[30:23];
   assign in_man = in_data[22:0];

   // S1: classify and compute the output bit position of the hidden one
   always_comb begin
      s1_cls_n = CL_NUM;
      s1_k_n   = {2'b00, in_exp} + K_OFS;
      if (in_exp == '1) begin
         s1_cls_n = (in_man != '0) ? CL_ZERO : CL_INF;
      end else if (in_exp == '0) begin
         s1_cls_n = CL_ZERO;
      end
   end

   assign sig_wide = {{(WIDE_W-MAN_W-1){1'b0}}, 1'b1, s1_man};

   // S2: align significand to the PCM grid, truncating toward zero
   always_comb begin
      s2_ovf_n = 1'b0;
      s2_mag_n = '0;
      if (s1_cls == CL_INF) begin
         s2_ovf_n = 1'b1;
      end else if (s1_cls == CL_NUM) begin
         if (s1_k > K_MAX) begin
            s2_ovf_n = 1'b1;
         end else if (s1_k[K_W-1]) begin
            s2_mag_n = '0;
         end else if (s1_k <= K_SIG) begin
            s2_mag_n = OUT_W'(sig_wide >> (6'(MAN_W) - s1_k[5:0]));
         end else begin
            s2_mag_n = OUT_W'(sig_wide << (s1_k[5:0] - 6'(MAN_W)));
         end
      end
   end

   // S3: apply sign and saturate; exactly -1.0 is representable
   always_comb begin
      s3_data_n = s2_mag;
      s3_clip_n = 1'b0;
      if (!s2_sign) begin
         if (s2_ovf || s2_mag[OUT_W-1]) begin
            s3_data_n = PCM_MAX;
            s3_clip_n = 1'b1;
         end
      end else begin
         if (s2_ovf || (s2_mag > PCM_MIN)) begin
            s3_data_n = PCM_MIN;
            s3_clip_n = 1'b1;
         end else if (s2_mag == PCM_MIN) begin
            s3_data_n = PCM_MIN;
         end else begin
            s3_data_n = OUT_W'(~s2_mag + 1'b1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_sign   <= 1'b0;
         s1_cls    <= CL_ZERO;
         s1_k      <= '0;
         s1_man    <= '0;
         s2_v      <= 1'b0;
         s2_sign   <= 1'b0;
         s2_ovf    <= 1'b0;
         s2_mag    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_clip  <= 1'b0;
      end else if (en) begin
         s1_v      <= in_valid;
         s1_sign   <= in_data[31];
         s1_cls    <= s1_cls_n;
         s1_k      <= s1_k_n;
         s1_man    <= in_man;
         s2_v      <= s1_v;
         s2_sign   <= s1_sign;
         s2_ovf    <= s2_ovf_n;
         s2_mag    <= s2_mag_n;
         out_valid <= s2_v;
         out_data  <= s3_data_n;
         out_clip  <= s2_v & s3_clip_n;
      end
   end

   // Clip monitor: clear wins over a same-cycle increment, sticks at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_cnt <= '0;
      end else if (clip_clr) begin
         clip_cnt <= '0;
      end else if (en && s2_v && s3_clip_n && (clip_cnt != CNT_MAX)) begin
         clip_cnt <= clip_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_float_to_pcm.sv
// Directed bench for float_to_pcm: a 24-bit/16-count build and a 16-bit/4-count
// build share the same stimulus; each output is compared to hand-derived values.
module tb_float_to_pcm;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        out_ready;
   logic        clip_clr;

   logic        in_ready;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_clip;
   logic [15:0] clip_cnt;

   logic        b_in_ready;
   logic [15:0] b_out_data;
   logic        b_out_valid;
   logic        b_out_clip;
   logic [3:0]  b_clip_cnt;

   int vectors;
   int miscompares;

   float_to_pcm #(.WIDTH(32), .OUT_W(24), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_clip(out_clip), .clip_clr(clip_clr),
      .clip_cnt(clip_cnt)
   );

   float_to_pcm #(.WIDTH(32), .OUT_W(16), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_clip(b_out_clip), .clip_clr(clip_clr),
      .clip_cnt(b_clip_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One isolated sample through both builds; result checked 3 edges after drive.
   task automatic run_one(input string tag, input logic [31:0] din,
                          input logic [23:0] e24, input logic c24,
                          input logic [15:0] e16, input logic c16);
      in_data  = din;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check({tag, "_v"},     32'(out_valid),  32'd1);
      check({tag, "_d24"},   32'(out_data),   32'(e24));
      check({tag, "_c24"},   32'(out_clip),   32'(c24));
      check({tag, "_d16"},   32'(b_out_data), 32'(e16));
      check({tag, "_c16"},   32'(b_out_clip), 32'(c16));
   endtask

   // Float encoding of n/16 for small positive n.
   function automatic logic [31:0] ramp_f(input int n);
      int          p;
      logic [31:0] t;
      logic [7:0]  e;
      p = 0;
      for (int i = 0; i < 8; i++) if (n[i]) p = i;
      t = 32'(n) << (23 - p);
      e = 8'(127 + p - 4);
      return {1'b0, e, t[22:0]};
   endfunction

   initial begin
      int          sent;
      int          got;
      int          stale;
      logic        acc;
      logic        outx;
      logic        stalled;
      logic [23:0] held;

      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_data     = '0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      clip_clr    = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_clip",  32'(out_clip),  32'd0);
      check("rst_clip_cnt",  32'(clip_cnt),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      rst_n = 1'b1;
      tick();

      // Back-to-back 0.5, -0.5, 0.25
      in_data = 32'h3F00_0000; in_valid = 1'b1;
      tick();
      in_data = 32'hBF00_0000;
      tick();
      check("lat_not_yet", 32'(out_valid), 32'd0);
      in_data = 32'h3E80_0000;
      tick();
      in_valid = 1'b0;
      check("b2b0_v",   32'(out_valid),  32'd1);
      check("b2b0_d",   32'(out_data),   32'h40_0000);
      check("b2b0_c",   32'(out_clip),   32'd0);
      check("b2b0_d16", 32'(b_out_data), 32'h4000);
      tick();
      check("b2b1_v",   32'(out_valid),  32'd1);
      check("b2b1_d",   32'(out_data),   32'hC0_0000);
      check("b2b1_c",   32'(out_clip),   32'd0);
      check("b2b1_d16", 32'(b_out_data), 32'hC000);
      tick();
      check("b2b2_v",   32'(out_valid),  32'd1);
      check("b2b2_d",   32'(out_data),   32'h20_0000);
      check("b2b2_c",   32'(out_clip),   32'd0);
      check("b2b2_d16", 32'(b_out_data), 32'h2000);
      tick();
      check("b2b_drain", 32'(out_valid), 32'd0);

      // Boundaries (24-bit and 16-bit builds)
      run_one("neg_one",  32'hBF80_0000, 24'h80_0000, 1'b0, 16'h8000, 1'b0);
      run_one("pos_one",  32'h3F80_0000, 24'h7F_FFFF, 1'b1, 16'h7FFF, 1'b1);
      run_one("pos_inf",  32'h7F80_0000, 24'h7F_FFFF, 1'b1, 16'h7FFF, 1'b1);
      run_one("neg_inf",  32'hFF80_0000, 24'h80_0000, 1'b1, 16'h8000, 1'b1);
      run_one("nan",      32'h7FC0_0000, 24'h00_0000, 1'b0, 16'h0000, 1'b0);
      run_one("tiny",     32'h3380_0000, 24'h00_0000, 1'b0, 16'h0000, 1'b0);
      run_one("neg_zero", 32'h8000_0000, 24'h00_0000, 1'b0, 16'h0000, 1'b0);
      run_one("trunc",    32'h3F7F_FFFF, 24'h7F_FFFF, 1'b0, 16'h7FFF, 1'b0);
      run_one("two",      32'h4000_0000, 24'h7F_FFFF, 1'b1, 16'h7FFF, 1'b1);
      tick();

      // Backpressure: out_ready pattern 1,0,0,1 over a 10-sample ramp
      sent = 0;
      got  = 0;
      in_data  = ramp_f(1);
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
         out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         #1;
         acc     = in_valid && in_ready;
         outx    = out_valid && out_ready;
         stalled = out_valid && !out_ready;
         held    = out_data;
         check("bp_in_ready", 32'(in_ready), stalled ? 32'd0 : 32'd1);
         if (outx) begin
            check("bp_data",   32'(out_data),   32'(got + 1) << 19);
            check("bp_data16", 32'(b_out_data), 32'(got + 1) << 11);
            got++;
         end
         tick();
         if (stalled) begin
            check("bp_hold_v", 32'(out_valid), 32'd1);
            check("bp_hold_d", 32'(out_data),  32'(held));
         end
         if (acc) begin
            sent++;
            if (sent < 10) in_data = ramp_f(sent + 1);
            else in_valid = 1'b0;
         end
      end
      check("bp_count", 32'(got), 32'd10);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      repeat (4) tick();

      // Clip counter: clear, then five clipped samples
      clip_clr = 1'b1;
      tick();
      clip_clr = 1'b0;
      check("cnt_clr",   32'(clip_cnt),   32'd0);
      check("cnt_clr_b", 32'(b_clip_cnt), 32'd0);
      in_data = 32'h4000_0000; in_valid = 1'b1;
      repeat (5) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("cnt_five",   32'(clip_cnt),   32'd5);
      check("cnt_five_b", 32'(b_clip_cnt), 32'd5);

      // Sixth clipped sample lands in S3 on the same edge as clip_clr
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      clip_clr = 1'b1;
      tick();
      clip_clr = 1'b0;
      check("clr_prio_clip", 32'(out_clip), 32'd1);
      check("clr_prio_cnt",  32'(clip_cnt), 32'd0);
      tick();
      check("clr_prio_hold", 32'(clip_cnt), 32'd0);

      // Saturation of the 4-bit counter after 20 clipped samples
      in_valid = 1'b1;
      repeat (20) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("cnt_sat_b",  32'(b_clip_cnt), 32'd15);
      check("cnt_twenty", 32'(clip_cnt),   32'd20);

      // Reset with three samples in flight
      in_data = 32'h4000_0000; in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      check("pre_rst_v", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_v",     32'(out_valid),  32'd0);
      check("midrst_d",     32'(out_data),   32'd0);
      check("midrst_cnt",   32'(clip_cnt),   32'd0);
      check("midrst_cnt_b", 32'(b_clip_cnt), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      stale = 0;
      repeat (6) begin
         tick();
         if (out_valid || b_out_valid) stale++;
      end
      check("no_stale", 32'(stale), 32'd0);

      // Pipe works again after reset
      run_one("post_rst", 32'h3F00_0000, 24'h40_0000, 1'b0, 16'h4000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
